// File: rtl/genius_pkg.sv
// Shared types and constants for the genius game controller.
package genius_pkg;

   localparam int unsigned STATE_W                = 3;
   localparam int unsigned AUTORESTART_CYCLES_DEF = 250_000_000;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_PREP   = 3'd2,
      ST_SEQ    = 3'd3,
      ST_PLAY   = 3'd4,
      ST_CHECK  = 3'd5,
      ST_NEXT   = 3'd6,
      ST_RESULT = 3'd7
   } state_t;

   typedef struct packed {
      logic r1;
      logic r2;
      logic e1;
      logic e2;
      logic e3;
      logic e4;
      logic sel;
   } ctrl_t;

endpackage

// File: rtl/genius_if.sv
// Controller <-> datapath signal bundle: status flags in, register/enable controls out.
interface genius_if;
   import genius_pkg::*;

   logic               enter;
   logic               end_FPGA;
   logic               end_User;
   logic               end_time;
   logic               win;
   logic               match;
   logic               R1;
   logic               R2;
   logic               E1;
   logic               E2;
   logic               E3;
   logic               E4;
   logic               SEL;
   logic [STATE_W-1:0] state_o;

   modport master (
      input  enter, end_FPGA, end_User, end_time, win, match,
      output R1, R2, E1, E2, E3, E4, SEL, state_o
   );

   modport slave (
      output enter, end_FPGA, end_User, end_time, win, match,
      input  R1, R2, E1, E2, E3, E4, SEL, state_o
   );
endinterface

// File: rtl/genius_controller.sv
// Moore FSM sequencing the genius game datapath.
// Optional RESULT timeout enabled by defining GENIUS_AUTORESTART_EN.
//
// state  | meaning
// INIT   | clear both datapath registers, one cycle
// SETUP  | wait for player to confirm level/mode (enter edge)
// PREP   | clear round register, then test win
// SEQ    | FPGA plays the sequence until end_FPGA
// PLAY   | user enters moves until end_User or end_time
// CHECK  | compare user entry, one cycle
// NEXT   | advance round counter, one cycle
// RESULT | show outcome, leave on enter edge (or timeout)
module genius_controller
   import genius_pkg::*;
#(
   parameter int unsigned AUTORESTART_CYCLES = AUTORESTART_CYCLES_DEF
) (
   input  logic      CLOCK_50,
   input  logic      reset,
   genius_if.master  bus
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_enter_d;
   logic   w_enter_rise;
   ctrl_t  w_ctrl;
   logic   w_leave_result;

   assign w_enter_rise = bus.enter & ~r_enter_d;

`ifdef GENIUS_AUTORESTART_EN
   logic [31:0] r_ar_cnt;
   logic        w_ar_done;

   assign w_ar_done = (r_ar_cnt == AUTORESTART_CYCLES - 32'd1);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_ar_cnt <= '0;
      end else if (r_state == ST_RESULT) begin
         r_ar_cnt <= r_ar_cnt + 32'd1;
      end else begin
         r_ar_cnt <= '0;
      end
   end

   assign w_leave_result = w_enter_rise | w_ar_done;
`else
   // Timeout length is irrelevant here; the block only anchors the parameter.
   if (AUTORESTART_CYCLES == 0) begin : g_no_timeout
   end

   assign w_leave_result = w_enter_rise;
`endif

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_INIT;
         r_enter_d <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_enter_d <= bus.enter;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:   w_state_nxt = ST_SETUP;
         ST_SETUP:  if (w_enter_rise) w_state_nxt = ST_PREP;
         ST_PREP:   w_state_nxt = bus.win ? ST_RESULT : ST_SEQ;
         ST_SEQ:    if (bus.end_FPGA) w_state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (bus.end_time) begin
               w_state_nxt = ST_RESULT;
            end else if (bus.end_User) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK:  w_state_nxt = bus.match ? ST_NEXT : ST_RESULT;
         ST_NEXT:   w_state_nxt = ST_PREP;
         ST_RESULT: if (w_leave_result) w_state_nxt = ST_INIT;
         default:   w_state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      w_ctrl = '0;
      case (r_state)
         ST_INIT:  begin w_ctrl.r1 = 1'b1; w_ctrl.r2  = 1'b1; end
         ST_SETUP: begin w_ctrl.e1 = 1'b1; w_ctrl.sel = 1'b1; end
         ST_PREP:  w_ctrl.r2 = 1'b1;
         ST_SEQ:   begin w_ctrl.e3 = 1'b1; w_ctrl.sel = 1'b1; end
         ST_PLAY:  begin w_ctrl.e2 = 1'b1; w_ctrl.sel = 1'b1; end
         ST_CHECK: w_ctrl.sel = 1'b1;
         ST_NEXT:  w_ctrl.e4 = 1'b1;
         default:  w_ctrl = '0;
      endcase
   end

   assign bus.R1      = w_ctrl.r1;
   assign bus.R2      = w_ctrl.r2;
   assign bus.E1      = w_ctrl.e1;
   assign bus.E2      = w_ctrl.e2;
   assign bus.E3      = w_ctrl.e3;
   assign bus.E4      = w_ctrl.e4;
   assign bus.SEL     = w_ctrl.sel;
   assign bus.state_o = r_state;

endmodule
